// File: rtl/demux_16x1_collector.sv
// demux_16x1_collector
//   Receiving end of the 16x1 serial mux path. An internal lane index walks
//   0..15 in lockstep with the mux, and each accepted bit is demuxed into the
//   matching shadow lane. The 16th bit completes the frame. That frame is
//   published on o_out with a level-valid / ack handshake. A sticky overrun
//   flag records any frame that was overwritten before it was acknowledged.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          asynchronous, active-high reset
//   i_in           serial data bit (mux output)
//   i_in_valid     i_in is accepted on this edge
//   i_clear        synchronous frame abort (index + shadow only)
//   i_frame_ack    consumer has taken o_out
//   o_sel[3:0]     lane the next accepted bit lands in
//   o_out[15:0]    last completed frame, bit i = bit accepted at sel=i
//   o_frame_valid  o_out holds an unacknowledged frame
//   o_overrun      sticky: a frame completed over an unacknowledged one
//   o_busy         partial frame in progress (sel != 0)

// One shadow lane: a single bit written when its demux line is selected.
module demux_16x1_collector_lane (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_we,
  input  logic i_d,
  output logic o_q
);
  logic r_q;

  // Clear beats write. Frame completion and abort both wipe the whole shadow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_q <= 1'b0;
    else if (i_clr) r_q <= 1'b0;
    else if (i_we)  r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module demux_16x1_collector (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in,
  input  logic        i_in_valid,
  input  logic        i_clear,
  input  logic        i_frame_ack,
  output logic [3:0]  o_sel,
  output logic [15:0] o_out,
  output logic        o_frame_valid,
  output logic        o_overrun,
  output logic        o_busy
);
  localparam int NUM_LANES = 16;
  localparam int SEL_W     = 4;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_LANES - 1);

  logic [SEL_W-1:0]     r_sel;
  logic [NUM_LANES-1:0] r_out;
  logic                 r_frame_valid;
  logic                 r_overrun;

  logic                 w_accept;
  logic                 w_complete;
  logic                 w_shadow_clr;
  logic [NUM_LANES-2:0] w_lane_we;
  logic [NUM_LANES-2:0] w_shadow;

  // Clear drops any same-edge in_valid.
  assign w_accept     = i_in_valid & ~i_clear;
  assign w_complete   = w_accept & (r_sel == LAST_SEL);
  assign w_shadow_clr = i_clear | w_complete;

  // The last lane has no shadow bit. Its data goes straight into o_out on
  // the completing edge, so only NUM_LANES-1 lanes are stored.
  for (genvar gi = 0; gi < NUM_LANES - 1; gi++) begin : g_lane
    // 1-to-16 demux of the registered index.
    assign w_lane_we[gi] = w_accept & (r_sel == SEL_W'(gi));

    demux_16x1_collector_lane u_lane (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (w_shadow_clr),
      .i_we  (w_lane_we[gi]),
      .i_d   (i_in),
      .o_q   (w_shadow[gi])
    );
  end

  // Lane index. It wraps 15 -> 0 naturally on the completing bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_sel <= '0;
    else if (i_clear)  r_sel <= '0;
    else if (w_accept) r_sel <= r_sel + 1'b1;
  end

  // Frame publish and handshake. Completion wins over a same-edge ack, so
  // the new frame stays valid. An ack alone drops valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out         <= '0;
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_complete) begin
        r_out         <= {i_in, w_shadow};
        r_frame_valid <= 1'b1;
        if (r_frame_valid && !i_frame_ack) r_overrun <= 1'b1;
      end else if (i_frame_ack) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign o_sel         = r_sel;
  assign o_out         = r_out;
  assign o_frame_valid = r_frame_valid;
  assign o_overrun     = r_overrun;
  assign o_busy        = (r_sel != '0);
endmodule

// File: tb/tb_demux_16x1_collector.sv
module tb_demux_16x1_collector;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_b = 1'b0, in_valid = 1'b0, clear = 1'b0, frame_ack = 1'b0;
  logic [3:0]  sel;
  logic [15:0] out;
  logic        frame_valid, overrun, busy;

  int checks = 0;
  int errors = 0;

  demux_16x1_collector dut (
    .i_clk(clk), .i_rst(rst), .i_in(in_b), .i_in_valid(in_valid),
    .i_clear(clear), .i_frame_ack(frame_ack),
    .o_sel(sel), .o_out(out), .o_frame_valid(frame_valid),
    .o_overrun(overrun), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: the accepted bits of the partial frame are kept as a list.
  bit          m_bits[$];
  logic [15:0] m_out;
  bit          m_fv, m_ov;

  typedef struct {
    bit          in, vld, clr, ack;
    logic [3:0]  e_sel;
    logic [15:0] e_out;
    bit          e_fv, e_ov;
  } vec_t;
  vec_t vt[20];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_out = '0; m_fv = 0; m_ov = 0;
  endtask

  task automatic model_edge(input bit i, input bit v, input bit c, input bit a);
    logic [15:0] f;
    if (c) begin
      m_bits.delete();
      if (a) m_fv = 0;
    end else if (v) begin
      m_bits.push_back(i);
      if (m_bits.size() == 16) begin
        f = '0;
        foreach (m_bits[k]) if (m_bits[k]) f = f | (16'd1 << k);
        if (m_fv && !a) m_ov = 1;
        m_out = f; m_fv = 1;
        m_bits.delete();
      end else if (a) m_fv = 0;
    end else if (a) m_fv = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".sel"},  {12'd0, sel}, 16'(m_bits.size()));
    chk({tag, ".out"},  out, m_out);
    chk({tag, ".fv"},   {15'd0, frame_valid}, {15'd0, m_fv});
    chk({tag, ".ov"},   {15'd0, overrun}, {15'd0, m_ov});
    chk({tag, ".busy"}, {15'd0, busy}, {15'd0, (m_bits.size() != 0)});
  endtask

  // Drive one cycle, update the model at the edge, and sample 1 ns later.
  task automatic tick(input bit i, input bit v, input bit c, input bit a, input string tag);
    in_b = i; in_valid = v; clear = c; frame_ack = a;
    @(posedge clk);
    model_edge(i, v, c, a);
    #1;
    chk_model(tag);
  endtask

  task automatic send_frame(input logic [15:0] w, input bit ack_last, input string tag);
    for (int k = 0; k < 16; k++)
      tick(w[k], 1'b1, 1'b0, (k == 15) ? ack_last : 1'b0, tag);
  endtask

  initial begin
    logic [15:0] word;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.sel", {12'd0, sel}, 16'd0);
    chk("rst.out", out, 16'd0);
    chk("rst.fv", {15'd0, frame_valid}, 16'd0);
    chk("rst.ov", {15'd0, overrun}, 16'd0);
    chk("rst.busy", {15'd0, busy}, 16'd0);
    #3 rst = 1'b0;

    // Table: all-ones sweep, ack, partial frame, clear
    for (int k = 0; k < 16; k++)
      vt[k] = '{1, 1, 0, 0, 4'((k + 1) % 16), (k == 15) ? 16'hFFFF : 16'h0000, (k == 15), 0};
    vt[16] = '{0, 0, 0, 1, 4'd0, 16'hFFFF, 0, 0};
    vt[17] = '{1, 1, 0, 0, 4'd1, 16'hFFFF, 0, 0};
    vt[18] = '{0, 1, 0, 0, 4'd2, 16'hFFFF, 0, 0};
    vt[19] = '{1, 1, 1, 0, 4'd0, 16'hFFFF, 0, 0};
    for (int k = 0; k < 20; k++) begin
      tick(vt[k].in, vt[k].vld, vt[k].clr, vt[k].ack, "tbl");
      chk("tbl.sel", {12'd0, sel}, {12'd0, vt[k].e_sel});
      chk("tbl.out", out, vt[k].e_out);
      chk("tbl.fv", {15'd0, frame_valid}, {15'd0, vt[k].e_fv});
      chk("tbl.ov", {15'd0, overrun}, {15'd0, vt[k].e_ov});
      chk("tbl.busy", {15'd0, busy}, {15'd0, (vt[k].e_sel != 0)});
    end

    // Pattern frame with gaps after lanes 3 and 9
    word = 16'hA5C3;
    for (int k = 0; k < 16; k++) begin
      tick(word[k], 1'b1, 1'b0, 1'b0, "gap");
      if (k == 3 || k == 9) begin
        tick(1'b1, 1'b0, 1'b0, 1'b0, "gap.idle");
        tick(1'b0, 1'b0, 1'b0, 1'b0, "gap.idle");
        chk("gap.sel_held", {12'd0, sel}, 16'(k + 1));
        chk("gap.busy", {15'd0, busy}, 16'd1);
      end
    end
    chk("gap.frame", out, 16'hA5C3);

    // Overrun: A5C3 still pending, then 1234 and 5678 with no ack
    send_frame(16'h1234, 1'b0, "ovr1");
    send_frame(16'h5678, 1'b0, "ovr2");
    chk("ovr.out", out, 16'h5678);
    chk("ovr.flag", {15'd0, overrun}, 16'd1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, "ovr.ack");
    chk("ovr.ack_fv", {15'd0, frame_valid}, 16'd0);
    chk("ovr.sticky", {15'd0, overrun}, 16'd1);

    // Ack on completing edge (after a fresh reset so overrun starts at 0)
    @(negedge clk); rst = 1'b1; model_reset(); #2 rst = 1'b0;
    send_frame(16'h1234, 1'b0, "ackc1");
    send_frame(16'h9ABC, 1'b1, "ackc2");
    chk("ackc.fv", {15'd0, frame_valid}, 16'd1);
    chk("ackc.no_ov", {15'd0, overrun}, 16'd0);
    chk("ackc.out", out, 16'h9ABC);

    // Clear mid-frame together with in_valid
    for (int k = 0; k < 7; k++) tick(1'b1, 1'b1, 1'b0, 1'b0, "clr.pre");
    tick(1'b1, 1'b1, 1'b1, 1'b0, "clr");
    chk("clr.sel", {12'd0, sel}, 16'd0);
    chk("clr.out_kept", out, 16'h9ABC);
    send_frame(16'h00FF, 1'b1, "clr.post");
    chk("clr.frame", out, 16'h00FF);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++)
      tick(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(19) == 0),
           ($urandom_range(6) == 0), "rnd");

    // Async reset mid-frame with frame_valid=1
    send_frame(16'hBEEF, 1'b0, "ar.pre");
    for (int k = 0; k < 10; k++) tick(1'b1, 1'b1, 1'b0, 1'b0, "ar.bits");
    chk("ar.fv_before", {15'd0, frame_valid}, 16'd1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar.sel", {12'd0, sel}, 16'd0);
    chk("ar.out", out, 16'd0);
    chk("ar.fv", {15'd0, frame_valid}, 16'd0);
    chk("ar.ov", {15'd0, overrun}, 16'd0);
    chk("ar.busy", {15'd0, busy}, 16'd0);
    #1 rst = 1'b0;
    model_reset();
    tick(1'b1, 1'b1, 1'b0, 1'b0, "ar.first");
    chk("ar.lane0", {12'd0, sel}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end
endmodule
